// File: rtl/sync_line_column_gen.sv
// sync_line_column_gen: separates hsync from vertical broad pulses and produces pixel coordinates, window enables and the gated target bit.
module sync_line_column_gen #(
  parameter int HSYNC_MIN   = 12,
  parameter int BROAD_MIN   = 60,
  parameter int BROAD_COUNT = 3,
  parameter int COL_START   = 8,
  parameter int COL_END     = 232,
  parameter int LINE_START  = 16,
  parameter int LINE_END    = 246
) (
  input  logic       clk4mhz,
  input  logic       reset,
  input  logic       csync_n,
  input  logic       video_bit,
  output logic       csync,
  output logic       vsync,
  output logic [8:0] lineCount,
  output logic [8:0] columnCount,
  output logic       en,
  output logic       xCounterEn,
  output logic       isTarget
);
  localparam logic [7:0] HMIN = 8'(HSYNC_MIN);
  localparam logic [7:0] BMIN = 8'(BROAD_MIN);
  localparam logic [2:0] BCNT = 3'(BROAD_COUNT);
  localparam logic [8:0] CS   = 9'(COL_START);
  localparam logic [8:0] CE   = 9'(COL_END);
  localparam logic [8:0] LS   = 9'(LINE_START);
  localparam logic [8:0] LE   = 9'(LINE_END);
  logic       csM, cs_s, cs_p, vidM, vid_s, riseQ;
  logic [7:0] lowCnt;
  logic [2:0] broadCnt, broadInc;
  logic       fall, rise, lineEv, broadEv, frameEv, xEnNext, enNext;
  logic [8:0] colNext, lineNext;
  always_comb begin
    fall     = cs_p & ~cs_s;
    rise     = ~cs_p & cs_s;
    lineEv   = riseQ && lowCnt >= HMIN && lowCnt < BMIN;
    broadEv  = riseQ && lowCnt >= BMIN;
    broadInc = broadCnt == 3'd7 ? 3'd7 : broadCnt + 3'd1;
    frameEv  = broadEv && broadInc == BCNT;
    colNext  = lineEv ? 9'd0 : columnCount == 9'd511 ? 9'd511 : columnCount + 9'd1;
    lineNext = frameEv ? 9'd0 : !lineEv ? lineCount : lineCount == 9'd511 ? 9'd511 : lineCount + 9'd1;
    xEnNext  = colNext >= CS && colNext < CE;
    enNext   = lineNext >= LS && lineNext < LE;
  end
  // rise is registered once more so classification sees a settled lowCnt
  always_ff @(posedge clk4mhz) begin
    if (reset) begin
      csM         <= 1'b1;
      cs_s        <= 1'b1;
      cs_p        <= 1'b1;
      vidM        <= 1'b0;
      vid_s       <= 1'b0;
      riseQ       <= 1'b0;
      lowCnt      <= 8'd0;
      broadCnt    <= 3'd0;
      columnCount <= 9'd0;
      lineCount   <= 9'd0;
      vsync       <= 1'b1;
      csync       <= 1'b1;
      xCounterEn  <= 1'b0;
      en          <= 1'b0;
      isTarget    <= 1'b0;
    end else begin
      csM         <= csync_n;
      cs_s        <= csM;
      cs_p        <= cs_s;
      vidM        <= video_bit;
      vid_s       <= vidM;
      riseQ       <= rise;
      lowCnt      <= fall ? 8'd1 : (!cs_s && lowCnt != 8'hFF) ? lowCnt + 8'd1 : lowCnt;
      broadCnt    <= lineEv ? 3'd0 : broadEv ? broadInc : broadCnt;
      columnCount <= colNext;
      lineCount   <= lineNext;
      vsync       <= frameEv ? 1'b0 : lineEv ? 1'b1 : vsync;
      csync       <= cs_s;
      xCounterEn  <= xEnNext;
      en          <= enNext;
      isTarget    <= vid_s & cs_s & xEnNext & enNext;
    end
  end
endmodule

// File: tb/tb_sync_line_column_gen.sv
// tb_sync_line_column_gen: directed vectors with hand-computed expectations for sync_line_column_gen.
module tb_sync_line_column_gen;
  logic       clk4mhz = 1'b0;
  logic       reset, csync_n, video_bit;
  logic       csync, vsync, en, xCounterEn, isTarget;
  logic [8:0] lineCount, columnCount;
  int         nChecks = 0;
  int         nErrors = 0;
  int         ln;
  sync_line_column_gen dut (
    .clk4mhz(clk4mhz), .reset(reset), .csync_n(csync_n), .video_bit(video_bit),
    .csync(csync), .vsync(vsync), .lineCount(lineCount), .columnCount(columnCount),
    .en(en), .xCounterEn(xCounterEn), .isTarget(isTarget)
  );
  always #5 clk4mhz = ~clk4mhz;
  task automatic check(input string tag, input int got, input int exp);
    nChecks++;
    if (got != exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk4mhz);
  endtask
  task automatic pulse(input int w, input int after);
    csync_n = 1'b0;
    step(w);
    csync_n = 1'b1;
    step(after);
  endtask
  task automatic nextLine();
    step(214);
    pulse(19, 4);
    ln++;
  endtask
  initial begin
    reset = 1'b1; csync_n = 1'b1; video_bit = 1'b0;
    step(2);
    reset = 1'b0;
    step(5);
    check("rst_col", columnCount, 5);
    check("rst_line", lineCount, 0);
    check("rst_vsync", vsync, 1);
    check("rst_csync", csync, 1);
    check("rst_en", en, 0);
    check("rst_xen", xCounterEn, 0);
    check("rst_tgt", isTarget, 0);
    csync_n = 1'b0;
    step(10);
    check("csync_low", csync, 0);
    step(9);
    csync_n = 1'b1;
    step(3);
    check("hs_col_pre", columnCount, 27);
    step(1);
    check("hs_col0", columnCount, 0);
    check("hs_line", lineCount, 1);
    check("hs_vsync", vsync, 1);
    pulse(9, 10);
    check("eq9_col", columnCount, 19);
    check("eq9_line", lineCount, 1);
    pulse(3, 10);
    check("gl3_col", columnCount, 32);
    pulse(11, 10);
    check("gl11_col", columnCount, 53);
    check("gl11_line", lineCount, 1);
    pulse(12, 4);
    check("hs12_col", columnCount, 0);
    check("hs12_line", lineCount, 2);
    pulse(59, 4);
    check("hs59_line", lineCount, 3);
    pulse(60, 20);
    pulse(108, 20);
    check("br2_line", lineCount, 3);
    check("br2_vsync", vsync, 1);
    pulse(108, 4);
    check("frame_line", lineCount, 0);
    check("frame_vsync", vsync, 0);
    pulse(108, 4);
    check("br4_line", lineCount, 0);
    check("br4_vsync", vsync, 0);
    pulse(19, 4);
    check("fhs_line", lineCount, 1);
    check("fhs_vsync", vsync, 1);
    check("fhs_col", columnCount, 0);
    ln = 1;
    repeat (9) nextLine();
    check("l10_line", lineCount, ln);
    video_bit = 1'b1;
    step(8);
    check("l10_col", columnCount, 8);
    check("l10_xen", xCounterEn, 1);
    check("l10_en", en, 0);
    check("l10_tgt", isTarget, 0);
    step(206);
    pulse(19, 4);
    ln++;
    repeat (9) nextLine();
    check("l20_line", lineCount, 20);
    check("l20_en", en, 1);
    step(7);
    check("c7_tgt", isTarget, 0);
    check("c7_xen", xCounterEn, 0);
    step(1);
    check("c8_col", columnCount, 8);
    check("c8_tgt", isTarget, 1);
    step(92);
    video_bit = 1'b0;
    step(2);
    check("vid_lat2", isTarget, 1);
    step(1);
    check("vid_lat3", isTarget, 0);
    video_bit = 1'b1;
    step(128);
    check("c231_col", columnCount, 231);
    check("c231_tgt", isTarget, 1);
    step(1);
    check("c232_tgt", isTarget, 0);
    check("c232_xen", xCounterEn, 0);
    step(600);
    check("los_col", columnCount, 511);
    check("los_xen", xCounterEn, 0);
    check("los_tgt", isTarget, 0);
    check("los_line", lineCount, 20);
    reset = 1'b1;
    step(1);
    check("mrst_col", columnCount, 0);
    check("mrst_line", lineCount, 0);
    check("mrst_vsync", vsync, 1);
    check("mrst_csync", csync, 1);
    check("mrst_en", en, 0);
    check("mrst_xen", xCounterEn, 0);
    check("mrst_tgt", isTarget, 0);
    reset = 1'b0;
    pulse(300, 4);
    check("stuck1_line", lineCount, 0);
    check("stuck1_vsync", vsync, 1);
    pulse(300, 4);
    pulse(300, 4);
    check("stuck3_vsync", vsync, 0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
